wb_commit_queue: RTL and testbench
==================================

# wb_commit_queue

Writeback commit queue between the execute/memory stages and the register file's single write port. Accepts writeback results through a valid/ready handshake, buffers them in order in a small FIFO and drains at most one entry per cycle into the register file (`IN`, `INADDRESS`, `WRITE`, `InstHIT`). It also forwards still-pending results to the decode-stage read ports, so operand reads always see the newest value.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `DATA_W`, 32: register data width.
- `ADDR_W`, 5: register address width.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RESET` in 1: reset; synchronous, active-high.
- `WB_VALID` in 1: writeback request valid.
- `WB_READY` out 1: queue can accept a request.
- `WB_ADDR` in `ADDR_W`: destination register.
- `WB_DATA` in `DATA_W`: result value.
- `RF_STALL` in 1: register file cannot accept a write this cycle.
- `RF_WRITE` out 1: write enable to the register file.
- `RF_INSTHIT` out 1: instruction-valid to the register file; always equal to `RF_WRITE`.
- `RF_INADDRESS` out `ADDR_W`: write address.
- `RF_IN` out `DATA_W`: write data.
- `LOOKUP1_ADDR`, `LOOKUP2_ADDR` in `ADDR_W`: operand addresses from decode.
- `FWD1_HIT`, `FWD2_HIT` out 1: a pending entry matches the lookup.
- `FWD1_DATA`, `FWD2_DATA` out `DATA_W`: forwarded value; 0 when there is no hit.
- `COUNT` out `log2(DEPTH)+1`: occupied entries.
- `EMPTY` out 1: `COUNT == 0`.

## Operation
- Storage: circular buffer with `head`/`tail` pointers of `log2(DEPTH)` bits that wrap modulo `DEPTH`, plus a `COUNT` register.
- Enqueue: occurs when `WB_VALID && WB_READY` at a rising edge.
  - `WB_READY = !RESET && (COUNT < DEPTH)`.
  - A request with `WB_ADDR == 0` is accepted (handshake completes) but is not stored; x0 is never written.
- Drain (combinational from head):
  - `RF_WRITE = !EMPTY && !RF_STALL && !RESET`.
  - `RF_INADDRESS` and `RF_IN` show the head entry, or 0 when empty.
  - The head entry is popped at the same edge at which the register file captures it.
- Simultaneous enqueue and pop: `COUNT` is unchanged and both pointers advance.
  - This cannot occur when the queue is full, because `WB_READY` is 0.
  - It can occur when `COUNT == 1`.
- Ordering: entries drain strictly in acceptance order. Duplicate destinations are all written, oldest first.
- Forwarding (per lookup port):
  - Compare against all valid entries, head included.
  - The youngest matching entry wins.
  - Address 0 never hits.
  - A request being presented on `WB_*` in the same cycle is not forwarded.
- State machine: none beyond occupancy. The states EMPTY (`COUNT == 0`), PARTIAL and FULL (`COUNT == DEPTH`) are derived from `COUNT`.

## Timing
- Reset values (sampled at the first rising edge with `RESET = 1`):
  - `COUNT = 0`, `head = tail = 0`, `EMPTY = 1`.
  - `WB_READY = 0` while `RESET` is high; 1 in the first cycle after.
  - `RF_WRITE = RF_INSTHIT = 0`, `RF_INADDRESS = 0`, `RF_IN = 0`.
  - `FWD*_HIT = 0`, `FWD*_DATA = 0`.
- Reset mid-operation discards all pending entries with no drain. The register file clears itself on the same `RESET`.
- Latency: a request accepted at edge N appears on `RF_*` after edge N and is written at edge N+1 when not stalled. Minimum accept-to-commit latency is 1 cycle.
- Forwarding outputs are valid combinationally in the cycle after acceptance. They remain valid up to and including the cycle the entry is presented on `RF_*`, and drop after the pop edge.
- `RF_STALL` holds the head. `RF_*` address and data stay stable while stalled.
- Throughput: one accept and one commit per cycle at steady state.

## Configuration
- `WB_BYPASS_EN` defined: the forwarding comparators and muxes are built as described above.
- `WB_BYPASS_EN` undefined: no comparators are built. `FWD1_HIT = FWD2_HIT = 0` and `FWD*_DATA = 0` constantly, and the lookup inputs are ignored. Decode must then stall on `!EMPTY` hazards. Queue behaviour is identical in both builds.

## Test plan
- **Reset then single write:** hold `RESET` 1 cycle, then `WB_ADDR = 2`, `WB_DATA = 95` for one cycle → `RF_WRITE = 1`, `RF_INADDRESS = 2`, `RF_IN = 95` in the next cycle; `EMPTY = 1` after the following edge.
- **Fill with stall:** `RF_STALL = 1`, enqueue x1..x4 with 10, 20, 30, 40 → `COUNT = 4`, `WB_READY = 0`, a fifth request is not accepted; release stall → writes x1..x4 in order over 4 cycles.
- **Forwarding:** stall held, enqueue x6 = 108 then x6 = 15, `LOOKUP1_ADDR = 6` → `FWD1_HIT = 1`, `FWD1_DATA = 15`; `LOOKUP2_ADDR = 0` → `FWD2_HIT = 0`. Without `WB_BYPASS_EN`, both hits are 0.
- **x0 drop:** enqueue `WB_ADDR = 0`, `WB_DATA = 50` → `WB_READY = 1` and the request is accepted, `COUNT` stays 0, `RF_WRITE` never asserts.
- **Simultaneous enqueue/pop with wrap:** stream 12 back-to-back requests with no stall → `COUNT` stays 1; `RF_IN` sequence matches the input with pointers wrapping 3 times.
- **Reset mid-operation:** with `COUNT = 3`, assert `RESET` → after the edge `COUNT = 0` and `RF_WRITE = 0`, and no queued entry is ever written.

Source files
------------

// File: rtl/wb_commit_queue.sv
// wb_commit_queue
//   Writeback commit queue. In-order FIFO between execute/memory writeback
//   and the register file's single write port. Accepts one result per cycle
//   via WB_VALID/WB_READY and drains at most one entry per cycle onto RF_*.
//   Pending results can be forwarded to two decode lookup ports.
//
//   Build option: define WB_BYPASS_EN to build the forwarding comparators.
//   Without it, FWD*_HIT/FWD*_DATA are tied to 0 and LOOKUP*_ADDR are ignored.
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   WB_VALID/WB_READY          writeback handshake
//   WB_ADDR, WB_DATA           destination register and value
//   RF_STALL                   register file refuses a write this cycle
//   RF_WRITE, RF_INSTHIT       register file write enable (identical)
//   RF_INADDRESS, RF_IN        head entry address/data (0 when empty)
//   LOOKUP1/2_ADDR             decode operand addresses
//   FWD1/2_HIT, FWD1/2_DATA    youngest pending match (0 when none)
//   COUNT, EMPTY               occupancy
//
// Occupancy (derived from COUNT, no separate state register)
//   state   | meaning
//   EMPTY   | COUNT == 0, nothing to commit
//   PARTIAL | 0 < COUNT < DEPTH, accepting and draining
//   FULL    | COUNT == DEPTH, WB_READY low

module wb_commit_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     WB_VALID,
    output logic                     WB_READY,
    input  logic [ADDR_W-1:0]        WB_ADDR,
    input  logic [DATA_W-1:0]        WB_DATA,
    input  logic                     RF_STALL,
    output logic                     RF_WRITE,
    output logic                     RF_INSTHIT,
    output logic [ADDR_W-1:0]        RF_INADDRESS,
    output logic [DATA_W-1:0]        RF_IN,
    input  logic [ADDR_W-1:0]        LOOKUP1_ADDR,
    input  logic [ADDR_W-1:0]        LOOKUP2_ADDR,
    output logic                     FWD1_HIT,
    output logic                     FWD2_HIT,
    output logic [DATA_W-1:0]        FWD1_DATA,
    output logic [DATA_W-1:0]        FWD2_DATA,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];

    logic empty;
    logic head_valid;
    logic push;
    logic pop;

    assign empty      = (count_q == '0);
    assign head_valid = !empty && !RESET;

    assign WB_READY   = !RESET && (count_q < FULL_CNT);
    assign RF_WRITE   = head_valid && !RF_STALL;
    assign RF_INSTHIT = RF_WRITE;

    assign RF_INADDRESS = head_valid ? mem_addr_q[head_q] : '0;
    assign RF_IN        = head_valid ? mem_data_q[head_q] : '0;

    assign COUNT = count_q;
    assign EMPTY = empty;

    // x0 requests complete the handshake but are never stored.
    assign push = WB_VALID && WB_READY && (WB_ADDR != '0);
    assign pop  = RF_WRITE;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        if (push) begin
            mem_addr_d[tail_q] = WB_ADDR;
            mem_data_d[tail_q] = WB_DATA;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: only entries inside [head, head+count)
    // are ever observed.
    always_ff @(posedge CLK) begin
        mem_addr_q <= mem_addr_d;
        mem_data_q <= mem_data_d;
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        FWD1_HIT  = 1'b0;
        FWD2_HIT  = 1'b0;
        FWD1_DATA = '0;
        FWD2_DATA = '0;
        fwd_idx   = head_q;
        if (!RESET) begin
            for (int k = 0; k < DEPTH; k++) begin
                fwd_idx = head_q + PTR_W'(k);
                if (CNT_W'(k) < count_q) begin
                    if (LOOKUP1_ADDR != '0 && mem_addr_q[fwd_idx] == LOOKUP1_ADDR) begin
                        FWD1_HIT  = 1'b1;
                        FWD1_DATA = mem_data_q[fwd_idx];
                    end
                    if (LOOKUP2_ADDR != '0 && mem_addr_q[fwd_idx] == LOOKUP2_ADDR) begin
                        FWD2_HIT  = 1'b1;
                        FWD2_DATA = mem_data_q[fwd_idx];
                    end
                end
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^{LOOKUP1_ADDR, LOOKUP2_ADDR};
    assign FWD1_HIT      = 1'b0;
    assign FWD2_HIT      = 1'b0;
    assign FWD1_DATA     = '0;
    assign FWD2_DATA     = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
module tb_wb_commit_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              WB_VALID;
    logic              WB_READY;
    logic [ADDR_W-1:0] WB_ADDR;
    logic [DATA_W-1:0] WB_DATA;
    logic              RF_STALL;
    logic              RF_WRITE;
    logic              RF_INSTHIT;
    logic [ADDR_W-1:0] RF_INADDRESS;
    logic [DATA_W-1:0] RF_IN;
    logic [ADDR_W-1:0] LOOKUP1_ADDR;
    logic [ADDR_W-1:0] LOOKUP2_ADDR;
    logic              FWD1_HIT;
    logic              FWD2_HIT;
    logic [DATA_W-1:0] FWD1_DATA;
    logic [DATA_W-1:0] FWD2_DATA;
    logic [2:0]        COUNT;
    logic              EMPTY;

    wb_commit_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .RF_STALL(RF_STALL), .RF_WRITE(RF_WRITE), .RF_INSTHIT(RF_INSTHIT),
        .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN),
        .LOOKUP1_ADDR(LOOKUP1_ADDR), .LOOKUP2_ADDR(LOOKUP2_ADDR),
        .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT),
        .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA),
        .COUNT(COUNT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void fwd_model(input logic [ADDR_W-1:0] la,
                                      output logic hit, output logic [DATA_W-1:0] dat);
        hit = 1'b0;
        dat = '0;
`ifdef WB_BYPASS_EN
        if (!RESET && la != '0) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].a == la) begin
                    hit = 1'b1;
                    dat = exp_q[i].d;
                end
            end
        end
`endif
    endfunction

    // Scoreboard monitor: inputs are stable at the falling edge and are what
    // the next rising edge will act on.
    always @(negedge CLK) begin
        logic              exp_rdy;
        logic              exp_wr;
        logic              exp_hv;
        logic              h1, h2;
        logic [DATA_W-1:0] d1, d2;
        if (mon_en) begin
            exp_rdy = !RESET && (exp_q.size() < DEPTH);
            exp_hv  = !RESET && (exp_q.size() > 0);
            exp_wr  = exp_hv && !RF_STALL;
            check("wb_ready", 32'(WB_READY), 32'(exp_rdy));
            check("count", 32'(COUNT), 32'(exp_q.size()));
            check("empty", 32'(EMPTY), 32'(exp_q.size() == 0));
            check("rf_write", 32'(RF_WRITE), 32'(exp_wr));
            check("rf_insthit", 32'(RF_INSTHIT), 32'(exp_wr));
            check("rf_inaddress", 32'(RF_INADDRESS), exp_hv ? 32'(exp_q[0].a) : 32'd0);
            check("rf_in", RF_IN, exp_hv ? exp_q[0].d : 32'd0);
            fwd_model(LOOKUP1_ADDR, h1, d1);
            fwd_model(LOOKUP2_ADDR, h2, d2);
            check("fwd1_hit", 32'(FWD1_HIT), 32'(h1));
            check("fwd1_data", FWD1_DATA, d1);
            check("fwd2_hit", 32'(FWD2_HIT), 32'(h2));
            check("fwd2_data", FWD2_DATA, d2);
            if (RESET) begin
                exp_q.delete();
            end else begin
                if (exp_wr) void'(exp_q.pop_front());
                if (WB_VALID && exp_rdy && WB_ADDR != '0)
                    exp_q.push_back('{a: WB_ADDR, d: WB_DATA});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_f1;
        RESET        = 1'b1;
        WB_VALID     = 1'b0;
        WB_ADDR      = '0;
        WB_DATA      = '0;
        RF_STALL     = 1'b0;
        LOOKUP1_ADDR = '0;
        LOOKUP2_ADDR = '0;
        tick();
        mon_en = 1'b1;
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_ready", 32'(WB_READY), 32'd0);
        tick();
        RESET = 1'b0;
        #1;
        check("ready_after_rst", 32'(WB_READY), 32'd1);

        // single write
        WB_VALID = 1'b1; WB_ADDR = 5'd2; WB_DATA = 32'd95;
        tick();
        WB_VALID = 1'b0;
        check("t1_write", 32'(RF_WRITE), 32'd1);
        check("t1_addr", 32'(RF_INADDRESS), 32'd2);
        check("t1_data", RF_IN, 32'd95);
        tick();
        check("t1_empty", 32'(EMPTY), 32'd1);

        // fill under stall, refuse a fifth, then drain in order
        RF_STALL = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            WB_VALID = 1'b1; WB_ADDR = 5'(i); WB_DATA = 32'(i * 10);
            tick();
        end
        check("t2_count", 32'(COUNT), 32'd4);
        check("t2_ready", 32'(WB_READY), 32'd0);
        WB_ADDR = 5'd5; WB_DATA = 32'd50;
        tick();
        check("t2_count_fifth", 32'(COUNT), 32'd4);
        WB_VALID = 1'b0;
        check("t2_stall_head", RF_IN, 32'd10);
        RF_STALL = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t2_drained", 32'(EMPTY), 32'd1);

        // forwarding with duplicate destinations
        RF_STALL = 1'b1;
        WB_VALID = 1'b1; WB_ADDR = 5'd6; WB_DATA = 32'd108;
        tick();
        WB_DATA = 32'd15;
        tick();
        WB_VALID = 1'b0;
        LOOKUP1_ADDR = 5'd6;
        LOOKUP2_ADDR = 5'd0;
        #1;
`ifdef WB_BYPASS_EN
        exp_f1 = 1'b1;
`else
        exp_f1 = 1'b0;
`endif
        check("t3_fwd1_hit", 32'(FWD1_HIT), 32'(exp_f1));
        check("t3_fwd1_data", FWD1_DATA, exp_f1 ? 32'd15 : 32'd0);
        check("t3_fwd2_hit", 32'(FWD2_HIT), 32'd0);
        RF_STALL = 1'b0;
        tick();
        tick();
        LOOKUP1_ADDR = '0;
        check("t3_drained", 32'(EMPTY), 32'd1);

        // x0 request is accepted but dropped
        WB_VALID = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'd50;
        #1;
        check("t4_ready", 32'(WB_READY), 32'd1);
        tick();
        WB_VALID = 1'b0;
        check("t4_count", 32'(COUNT), 32'd0);
        check("t4_nowrite", 32'(RF_WRITE), 32'd0);
        tick();

        // back-to-back stream, pointers wrap three times
        for (int i = 0; i < 12; i++) begin
            WB_VALID = 1'b1;
            WB_ADDR  = 5'(1 + (i % 31));
            WB_DATA  = 32'h1000 + 32'(i * 7);
            tick();
            check("t5_count_one", 32'(COUNT), 32'd1);
        end
        WB_VALID = 1'b0;
        tick();
        check("t5_drained", 32'(EMPTY), 32'd1);

        // reset with three pending entries
        RF_STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WB_VALID = 1'b1; WB_ADDR = 5'(7 + i); WB_DATA = 32'(700 + i);
            tick();
        end
        WB_VALID = 1'b0;
        check("t6_count3", 32'(COUNT), 32'd3);
        RESET = 1'b1;
        tick();
        check("t6_count0", 32'(COUNT), 32'd0);
        RESET    = 1'b0;
        RF_STALL = 1'b0;
        #1;
        check("t6_nowrite", 32'(RF_WRITE), 32'd0);
        tick();
        tick();

        // random traffic with stalls, x0 and duplicate destinations
        for (int i = 0; i < 300; i++) begin
            WB_VALID     = 1'($urandom_range(0, 1));
            WB_ADDR      = 5'($urandom_range(0, 7));
            WB_DATA      = $urandom;
            RF_STALL     = ($urandom_range(0, 2) == 0);
            LOOKUP1_ADDR = 5'($urandom_range(0, 7));
            LOOKUP2_ADDR = 5'($urandom_range(0, 7));
            tick();
        end
        WB_VALID = 1'b0;
        RF_STALL = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("final_drain", 32'(exp_q.size()), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
